// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch sequencer: reset PC,
// fetch state encodings, the canonical nop and a compressed-encoding test.
package fetch_ctrl_pkg;

  localparam logic [63:0] PMEM_START = 64'h8000_0000;

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_VALID = 2'd3;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // RVC encodings are the ones whose two low bits are not both set.
  function automatic logic inst_is_compressed(input logic [1:0] i_lsbs);
    return i_lsbs != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_ctrl_redirect_mux.sv
// Redirect source arbitration: exception > mret > branch.
// Computes the trap vector (direct or vectored mtvec) and always returns a
// halfword-aligned target. Purely combinational so ifetch can reuse it.
module redirect_mux #(
  parameter int XLEN = 64
) (
  input  logic            i_exception,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mcause,
  input  logic            i_mret,
  input  logic [XLEN-1:0] i_mepc,
  input  logic            i_branch,
  input  logic [XLEN-1:0] i_branch_target,
  output logic            o_redir,
  output logic [XLEN-1:0] o_target
);

  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_trap;
  logic [XLEN-1:0] w_sel;

  // Trap vector and priority select; lower-priority sources are simply dropped.
  always_comb begin
    w_base = i_mtvec & ~XLEN'(3);
    w_trap = i_mtvec[0] ? (w_base + (i_mcause << 2)) : w_base;
    if (i_exception) begin
      w_sel = w_trap;
    end else if (i_mret) begin
      w_sel = i_mepc;
    end else begin
      w_sel = i_branch_target;
    end
  end

  assign o_redir  = i_exception | i_mret | i_branch;
  assign o_target = w_sel & ~XLEN'(1);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer between the fetch stage and instruction memory.
// Owns the PC, issues one outstanding imem request at a time, discards
// responses made stale by a redirect and holds the fetched instruction
// while decode stalls.
// Optional build macro IFU_PERF_CNT_EN adds three 64-bit wrapping
// performance counters (consumed fetches, redirect cycles, stall cycles).
module fetch_ctrl #(
  parameter logic [63:0] PMEM_START = fetch_ctrl_pkg::PMEM_START,
  parameter int          XLEN       = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            exception_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mcause_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_resp_valid_i,
  input  logic [31:0]     imem_resp_data_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     inst_o,
`ifdef IFU_PERF_CNT_EN
  output logic [63:0]     perf_fetch_o,
  output logic [63:0]     perf_redirect_o,
  output logic [63:0]     perf_stall_o,
`endif
  output logic            is_compressed_o
);

  import fetch_ctrl_pkg::*;

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_inst;
  logic            r_valid;

  logic            w_redir;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_seq;
  logic            w_hs;
  logic            w_consume;
  logic            w_stalled;

  redirect_mux #(
    .XLEN (XLEN)
  ) u_redirect_mux (
    .i_exception     (exception_i),
    .i_mtvec         (mtvec_i),
    .i_mcause        (mcause_i),
    .i_mret          (mret_i),
    .i_mepc          (mepc_i),
    .i_branch        (branch_i),
    .i_branch_target (branch_target_i),
    .o_redir         (w_redir),
    .o_target        (w_target)
  );

  assign w_pc_seq  = r_pc + (inst_is_compressed(r_inst[1:0]) ? XLEN'(2) : XLEN'(4));
  assign w_hs      = (r_state == S_REQ) && imem_req_ready_i;
  assign w_consume = (r_state == S_VALID) && !w_redir && !stall_i;
  assign w_stalled = (r_state == S_VALID) && !w_redir && stall_i;

  // Fetch FSM: PC update, request tracking, stale-response drain and hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_REQ;
      r_pc    <= PMEM_START;
      r_valid <= 1'b0;
      r_inst  <= NOP_INST;
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_redir) r_pc <= w_target;
          // A request accepted in a redirect cycle fetches the old PC, so
          // its response must be thrown away.
          if (w_hs) r_state <= w_redir ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          if (w_redir) begin
            r_pc    <= w_target;
            r_state <= imem_resp_valid_i ? S_REQ : S_DRAIN;
          end else if (imem_resp_valid_i) begin
            r_inst  <= imem_resp_data_i;
            r_valid <= 1'b1;
            r_state <= S_VALID;
          end
        end
        S_DRAIN: begin
          if (w_redir) r_pc <= w_target;
          if (imem_resp_valid_i) r_state <= S_REQ;
        end
        S_VALID: begin
          if (w_redir) begin
            r_valid <= 1'b0;
            r_pc    <= w_target;
            r_state <= S_REQ;
          end else if (!stall_i) begin
            r_valid <= 1'b0;
            r_pc    <= w_pc_seq;
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  assign imem_req_valid_o = (r_state == S_REQ) && !reset;
  assign imem_req_addr_o  = r_pc;
  assign valid_o          = r_valid;
  assign pc_o             = r_pc;
  assign inst_o           = r_inst;
  assign is_compressed_o  = inst_is_compressed(r_inst[1:0]);

`ifdef IFU_PERF_CNT_EN
  logic [63:0] r_perf_fetch;
  logic [63:0] r_perf_redirect;
  logic [63:0] r_perf_stall;

  // Free-running wrapping event counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_perf_fetch    <= 64'd0;
      r_perf_redirect <= 64'd0;
      r_perf_stall    <= 64'd0;
    end else begin
      r_perf_fetch    <= r_perf_fetch + 64'(w_consume);
      r_perf_redirect <= r_perf_redirect + 64'(w_redir);
      r_perf_stall    <= r_perf_stall + 64'(w_stalled);
    end
  end

  assign perf_fetch_o    = r_perf_fetch;
  assign perf_redirect_o = r_perf_redirect;
  assign perf_stall_o    = r_perf_stall;
`else
  logic w_unused_perf;
  assign w_unused_perf = w_stalled;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model of the fetch sequencer and
// a behavioural imem with programmable response latency.
module tb_fetch_ctrl;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, stall_i, exception_i, mret_i, branch_i;
  logic [63:0] mtvec_i, mcause_i, mepc_i, branch_target_i;
  logic        imem_req_ready_i, imem_resp_valid_i;
  logic [31:0] imem_resp_data_i;
  logic        imem_req_valid_o, valid_o, is_compressed_o;
  logic [63:0] imem_req_addr_o, pc_o;
  logic [31:0] inst_o;
`ifdef IFU_PERF_CNT_EN
  logic [63:0] perf_fetch_o, perf_redirect_o, perf_stall_o;
`endif

  fetch_ctrl dut (
    .clock             (clock),
    .reset             (reset),
    .stall_i           (stall_i),
    .exception_i       (exception_i),
    .mtvec_i           (mtvec_i),
    .mcause_i          (mcause_i),
    .mret_i            (mret_i),
    .mepc_i            (mepc_i),
    .branch_i          (branch_i),
    .branch_target_i   (branch_target_i),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_req_addr_o   (imem_req_addr_o),
    .imem_resp_valid_i (imem_resp_valid_i),
    .imem_resp_data_i  (imem_resp_data_i),
    .valid_o           (valid_o),
    .pc_o              (pc_o),
    .inst_o            (inst_o),
`ifdef IFU_PERF_CNT_EN
    .perf_fetch_o      (perf_fetch_o),
    .perf_redirect_o   (perf_redirect_o),
    .perf_stall_o      (perf_stall_o),
`endif
    .is_compressed_o   (is_compressed_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Stimulus knobs for the next cycle.
  logic        d_rst, d_stall, d_exc, d_mret, d_br, d_rdy;
  logic [63:0] d_mtvec, d_mcause, d_mepc, d_btgt;
  int          next_lat;
  logic [31:0] next_data;
  logic        spur_en;

  // Behavioural imem.
  logic        im_pend;
  int          im_cnt;
  logic [31:0] im_data;

  // Reference model: PC, request in flight, in-flight response known stale,
  // instruction presented to decode.
  logic        model_ok;
  logic [63:0] m_pc;
  logic        m_out, m_stale, m_hold;
  logic [31:0] m_inst;
  logic [63:0] m_pf, m_pr, m_ps;

  function automatic logic [63:0] ref_target(input logic exc, input logic mr,
                                              input logic [63:0] tvec, input logic [63:0] cause,
                                              input logic [63:0] epc, input logic [63:0] bt);
    logic [63:0] t;
    if (exc) t = (tvec - (tvec % 4)) + ((tvec % 2 == 1) ? cause * 4 : 64'd0);
    else if (mr) t = epc;
    else t = bt;
    return t - (t % 2);
  endfunction

  task automatic idle();
    d_stall = 0; d_exc = 0; d_mret = 0; d_br = 0; d_rdy = 0;
  endtask

  // One clock cycle: drive, check the current outputs, advance the model.
  task automatic cyc();
    logic        rv, rd, hs, exp_req;
    logic [31:0] rdat;
    logic [63:0] tgt;
    rv   = 1'b0;
    rdat = $urandom;
    if (im_pend) begin
      im_cnt--;
      if (im_cnt == 0) begin
        rv      = 1'b1;
        rdat    = im_data;
        im_pend = 1'b0;
      end
    end else if (spur_en && ($urandom_range(0, 7) == 0)) begin
      rv = 1'b1;
    end
    reset = d_rst; stall_i = d_stall; exception_i = d_exc; mret_i = d_mret;
    branch_i = d_br; mtvec_i = d_mtvec; mcause_i = d_mcause; mepc_i = d_mepc;
    branch_target_i = d_btgt; imem_req_ready_i = d_rdy;
    imem_resp_valid_i = rv; imem_resp_data_i = rdat;
    #1;
    exp_req = !d_rst && !m_out && !m_hold;
    if (model_ok) begin
      chk("req_valid", 64'(imem_req_valid_o), 64'(exp_req));
      if (exp_req) chk("req_addr", imem_req_addr_o, m_pc);
      chk("valid", 64'(valid_o), 64'(m_hold));
      if (m_hold) begin
        chk("pc", pc_o, m_pc);
        chk("inst", 64'(inst_o), 64'(m_inst));
        chk("compressed", 64'(is_compressed_o), 64'(m_inst[1:0] != 2'b11));
      end
`ifdef IFU_PERF_CNT_EN
      chk("perf_fetch", perf_fetch_o, m_pf);
      chk("perf_redirect", perf_redirect_o, m_pr);
      chk("perf_stall", perf_stall_o, m_ps);
`endif
    end
    rd  = d_exc | d_mret | d_br;
    tgt = ref_target(d_exc, d_mret, d_mtvec, d_mcause, d_mepc, d_btgt);
    hs  = exp_req && d_rdy;
    @(posedge clock);
    if (d_rst) begin
      model_ok = 1'b1;
      m_pc = 64'h8000_0000; m_out = 0; m_stale = 0; m_hold = 0;
      m_pf = 0; m_pr = 0; m_ps = 0;
      im_pend = 1'b0;
    end else begin
      if (m_hold && !rd && !d_stall) m_pf = m_pf + 1;
      if (rd) m_pr = m_pr + 1;
      if (m_hold && d_stall && !rd) m_ps = m_ps + 1;
      if (m_hold) begin
        if (rd) begin
          m_hold = 0; m_pc = tgt;
        end else if (!d_stall) begin
          m_hold = 0;
          m_pc = m_pc + ((m_inst[1:0] != 2'b11) ? 64'd2 : 64'd4);
        end
      end else if (!m_out) begin
        if (rd) m_pc = tgt;
        if (hs) begin
          m_out = 1; m_stale = rd;
          im_pend = 1; im_cnt = next_lat; im_data = next_data;
        end
      end else begin
        if (rv) begin
          m_out = 0;
          if (!m_stale && !rd) begin
            m_hold = 1; m_inst = rdat;
          end
        end
        if (rd) begin
          m_pc = tgt; m_stale = 1;
        end
      end
    end
    @(negedge clock);
  endtask

  // Handshake a request now and let its response arrive after lat cycles.
  task automatic fetch(input logic [31:0] data, input int lat);
    next_data = data; next_lat = lat;
    d_rdy = 1; cyc();
    d_rdy = 0; repeat (lat) cyc();
  endtask

  initial begin
    model_ok = 0; m_hold = 0; m_out = 0; m_stale = 0; m_pc = 0; m_inst = 0;
    m_pf = 0; m_pr = 0; m_ps = 0;
    im_pend = 0; im_cnt = 0; im_data = 0; spur_en = 0;
    next_lat = 1; next_data = 32'h13;
    d_mtvec = 0; d_mcause = 0; d_mepc = 0; d_btgt = 0;
    idle(); d_rst = 1;
    @(negedge clock);
    repeat (3) cyc();
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_inst", 64'(inst_o), 64'h13);
    chk("rst_compressed", 64'(is_compressed_o), 64'd0);
    chk("rst_addr", imem_req_addr_o, 64'h8000_0000);
    chk("rst_req_valid", 64'(imem_req_valid_o), 64'd0);

    // First fetch after reset release, then sequential +4.
    d_rst = 0;
    fetch(32'h0000_0513, 1);
    chk("first_valid", 64'(valid_o), 64'd1);
    chk("first_inst", 64'(inst_o), 64'h513);
    chk("first_pc", pc_o, 64'h8000_0000);
    cyc();
    chk("seq4_addr", imem_req_addr_o, 64'h8000_0004);

    // Compressed instruction advances by 2.
    fetch(32'h0000_4501, 1);
    chk("rvc_flag", 64'(is_compressed_o), 64'd1);
    cyc();
    chk("seq2_addr", imem_req_addr_o, 64'h8000_0006);

    // Branch in S_REQ without handshake, then wrap at the top of memory.
    d_br = 1; d_btgt = 64'hFFFF_FFFF_FFFF_FFFC;
    cyc(); idle();
    chk("br_noreq_addr", imem_req_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("br_noreq_reqv", 64'(imem_req_valid_o), 64'd1);
    fetch(32'h0000_0013, 2);
    cyc();
    chk("wrap_addr", imem_req_addr_o, 64'h0);

    // Decode stall holds the instruction; exception wins over stall.
    fetch(32'h00a0_0093, 1);
    d_stall = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_valid", 64'(valid_o), 64'd1);
      chk("stall_pc", pc_o, 64'h0);
      chk("stall_inst", 64'(inst_o), 64'h00a0_0093);
      chk("stall_noreq", 64'(imem_req_valid_o), 64'd0);
    end
    d_exc = 1; d_mtvec = 64'h8000_1001; d_mcause = 64'd7;
    cyc(); idle();
    chk("exc_valid", 64'(valid_o), 64'd0);
    chk("exc_vec_addr", imem_req_addr_o, 64'h8000_101C);

    // Branch while waiting: the late response is drained.
    next_lat = 5; next_data = 32'h0010_0093;
    d_rdy = 1; cyc(); idle();
    d_br = 1; d_btgt = 64'h8000_0100;
    cyc(); idle();
    chk("drain_reqv", 64'(imem_req_valid_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("drain_valid", 64'(valid_o), 64'd0);
    end
    chk("drain_addr", imem_req_addr_o, 64'h8000_0100);
    chk("drain_done_reqv", 64'(imem_req_valid_o), 64'd1);

    // All three redirects at once: exception wins (direct mode).
    d_exc = 1; d_mret = 1; d_br = 1;
    d_mtvec = 64'h8000_2000; d_mcause = 64'd5; d_mepc = 64'h8000_0040; d_btgt = 64'h8000_0300;
    cyc(); idle();
    chk("prio_addr", imem_req_addr_o, 64'h8000_2000);

    // Branch in S_REQ with ready high: drain before the new request.
    d_br = 1; d_btgt = 64'h8000_0280; d_rdy = 1; next_lat = 2;
    cyc(); idle();
    chk("br_hs_reqv0", 64'(imem_req_valid_o), 64'd0);
    cyc();
    chk("br_hs_reqv1", 64'(imem_req_valid_o), 64'd0);
    cyc();
    chk("br_hs_reqv2", 64'(imem_req_valid_o), 64'd1);
    chk("br_hs_addr", imem_req_addr_o, 64'h8000_0280);
    chk("br_hs_valid", 64'(valid_o), 64'd0);

    // Randomized traffic.
    spur_en = 1;
    for (int n = 0; n < 3000; n++) begin
      d_rst    = ($urandom_range(0, 99) == 0);
      d_stall  = ($urandom_range(0, 9) < 4);
      d_exc    = ($urandom_range(0, 15) == 0);
      d_mret   = ($urandom_range(0, 15) == 0);
      d_br     = ($urandom_range(0, 7) == 0);
      d_rdy    = $urandom_range(0, 1);
      d_mtvec  = {$urandom, $urandom};
      d_mcause = 64'($urandom_range(0, 63));
      d_mepc   = {$urandom, $urandom};
      d_btgt   = ($urandom_range(0, 7) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                              : {32'h0, $urandom};
      next_lat  = $urandom_range(1, 4);
      next_data = $urandom;
      if ($urandom_range(0, 1) == 1) next_data[1:0] = 2'b11;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
